fp_mul_round_normalize: RTL and testbench
=========================================

FP_MUL_ROUND_NORMALIZE -- requirements
Module: fp_mul_round_normalize

Interface
REQ-001 clk  input  1  sole clock, rising-edge active.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 iValid  input  1  upstream product present this cycle.
REQ-004 oReady  output  1  block accepts the input this cycle; transfer occurs when iValid & oReady.
REQ-005 iSign  input  1  result sign (XOR of operand signs).
REQ-006 iExp  input  10  two's-complement biased exponent sum (expA + expB - 127); range -127..381.
REQ-007 iFrac  input  48  raw 24x24 mantissa product; the integer part is in bits [47:46].
REQ-008 iZero  input  1  either operand is zero; forces a signed-zero result.
REQ-009 oValid  output  1  result present this cycle.
REQ-010 iReady  input  1  downstream accepts the result; transfer occurs when oValid & iReady.
REQ-011 oZ  output  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-012 oOverflow, oUnderflow, oInexact  output  1 each  status flags, qualified by oValid.

Function
REQ-013 The block SHALL be a 2-stage pipeline (S1 normalize, S2 round/pack) with a latency of exactly 2 cycles from input transfer to oValid when not stalled.
- S1 normalize, when iFrac[47]=1: mant=iFrac[46:24], guard=iFrac[23], sticky=|iFrac[22:0], exp=iExp+1.
- S1 normalize, when iFrac[47]=0: mant=iFrac[45:23], guard=iFrac[22], sticky=|iFrac[21:0], exp=iExp.
REQ-015 S2 SHALL round to nearest even: increment when guard & (sticky | mant[0]).
- On mantissa carry-out: mant=0, exp=exp+1.
REQ-016 oInexact SHALL equal guard|sticky for finite, non-zero results.
REQ-017 Overflow: when the final exp >= 255, oZ={sign,8'hFF,23'h0}, oOverflow=1, oInexact=1.
REQ-018 Underflow: when the final exp <= 0, oZ={sign,31'h0}, oUnderflow=1, oInexact=1 (flush to zero, no denormals).
REQ-019 iZero=1 SHALL yield oZ={sign,31'h0}, with all flags 0; it overrides REQ-017 and REQ-018.
REQ-020 S2 SHALL load when ~oValid | iReady; otherwise oZ, the flags and oValid hold stable.
REQ-021 S1 SHALL advance when S1 is empty or S2 loads.
- oReady = ~s1Valid | s2Load (combinational from iReady is permitted).
REQ-022 Occupancy SHALL never exceed 2, and no accepted input is dropped or duplicated under any iReady pattern.
REQ-023 With simultaneous input accept and output transfer, full throughput of 1 result per cycle SHALL be sustained.

Reset
REQ-024 On reset, S1 and S2 valid bits, oValid, oZ and all flags SHALL go to 0 immediately.
- oReady SHALL read 1 once reset is low.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight entries, and no oValid SHALL follow reset release without a new input.

Structure
REQ-026 A shared package SHALL hold:
- FP32 field widths (1/8/23).
- BIAS=127 and EXP_MAX=255.
- Product width 48.
- Internal exponent width 10.
REQ-027 Rounding and packing SHALL be one combinational sub-module, fp_round_rne (inputs: sign, exp, mant, guard, sticky, zero; outputs: packed word and flags).
- The pipeline registers and handshake SHALL stay in the top module.

Verification
REQ-028 iFrac=48'h4000_0000_0000, iExp=127, iSign=0 -> oZ=32'h3F80_0000 two cycles later, flags 0.
REQ-029 iFrac=48'h9000_0000_0000 (1.5*1.5), iExp=127 -> oZ=32'h4010_0000, oInexact=0.
REQ-030 Rounding cases at iExp=127:
- iFrac=48'h4000_0040_0000 (tie, even) -> oZ=32'h3F80_0000, oInexact=1.
- iFrac=48'h4000_00C0_0000 (tie, odd) -> oZ=32'h3F80_0002, oInexact=1.
- iFrac=48'h7FFF_FFC0_0000 (carry-out) -> oZ=32'h4000_0000.
REQ-031 Overflow/underflow/zero:
- iExp=254, iFrac=48'h8000_0000_0000, iSign=1 -> oZ=32'hFF80_0000, oOverflow=1.
- iExp=0, iFrac=48'h4000_0000_0000 -> oZ=32'h0000_0000, oUnderflow=1.
- iZero=1, iSign=1 -> oZ=32'h8000_0000, flags 0.
REQ-032 Backpressure: 4 back-to-back inputs with iReady=0 for cycles 2-5 -> oReady falls after 2 accepts, oZ holds stable, and all 4 results emerge in order once iReady=1.
REQ-033 Reset pulse while 2 entries are in flight -> oValid=0 on the same cycle, and no stale result appears after release.

Source files
------------

// File: rtl/fp_mul_round_normalize_pkg.sv
// Shared widths, limits and pipeline bundles for the
// FP32 multiplier normalize/round back end.
package fp_mul_round_normalize_pkg;
  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_W = FP_SIGN_W + FP_EXP_W + FP_FRAC_W;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int PROD_W  = 48;
  localparam int IEXP_W  = 10;

  localparam logic [IEXP_W-1:0] EXP_TOP = IEXP_W'(EXP_MAX);

  typedef struct packed {
    logic              sign;
    logic [IEXP_W-1:0] exp;
    logic [FP_FRAC_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              zero;
  } s1_t;

  typedef struct packed {
    logic [FP_W-1:0] z;
    logic            ovf;
    logic            unf;
    logic            inx;
  } res_t;
endpackage

// File: rtl/fp_mul_round_normalize_if.sv
// Valid/ready bundle carrying the raw product in and
// the packed FP32 result plus status flags out.
interface fp_mul_round_normalize_if;
  import fp_mul_round_normalize_pkg::*;

  logic              iValid;
  logic              oReady;
  logic              iSign;
  logic [IEXP_W-1:0] iExp;
  logic [PROD_W-1:0] iFrac;
  logic              iZero;
  logic              oValid;
  logic              iReady;
  logic [FP_W-1:0]   oZ;
  logic              oOverflow;
  logic              oUnderflow;
  logic              oInexact;

  modport slave (
    input  iValid, iSign, iExp, iFrac,
    input  iZero, iReady,
    output oReady, oValid, oZ,
    output oOverflow, oUnderflow, oInexact
  );

  modport master (
    output iValid, iSign, iExp, iFrac,
    output iZero, iReady,
    input  oReady, oValid, oZ,
    input  oOverflow, oUnderflow, oInexact
  );
endinterface

// File: rtl/fp_mul_round_normalize_round.sv
// Round-to-nearest-even and FP32 pack with
// overflow saturation and flush-to-zero underflow.
module fp_round_rne
  import fp_mul_round_normalize_pkg::*;
(
  input  logic                 sign,
  input  logic [IEXP_W-1:0]    exp,
  input  logic [FP_FRAC_W-1:0] mant,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic                 zero,
  output logic [FP_W-1:0]      z,
  output logic                 ovf,
  output logic                 unf,
  output logic                 inx
);
  logic                 rnd_up;
  logic [FP_FRAC_W:0]   sum;
  logic [IEXP_W-1:0]    exp_f;

  always_comb begin
    rnd_up = guard & (sticky | mant[0]);
    sum    = {1'b0, mant}
           + {{FP_FRAC_W{1'b0}}, rnd_up};
    exp_f  = exp
           + {{(IEXP_W-1){1'b0}}, sum[FP_FRAC_W]};
    z   = {sign, {(FP_W-1){1'b0}}};
    ovf = 1'b0;
    unf = 1'b0;
    inx = 1'b0;
    // zero operand wins over any exponent range result
    if (!zero) begin
      if ($signed(exp_f) >= $signed(EXP_TOP)) begin
        z   = {sign, {FP_EXP_W{1'b1}},
               {FP_FRAC_W{1'b0}}};
        ovf = 1'b1;
        inx = 1'b1;
      end else if ($signed(exp_f) <=
                   $signed({IEXP_W{1'b0}})) begin
        unf = 1'b1;
        inx = 1'b1;
      end else begin
        z   = {sign, exp_f[FP_EXP_W-1:0],
               sum[FP_FRAC_W-1:0]};
        inx = guard | sticky;
      end
    end
  end
endmodule

// File: rtl/fp_mul_round_normalize.sv
// Two-stage normalize / round-pack pipeline with
// valid/ready flow control between the stages.
module fp_mul_round_normalize
  import fp_mul_round_normalize_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  fp_mul_round_normalize_if.slave  io
);
  logic s1_valid_q, s1_valid_d;
  logic o_valid_q, o_valid_d;
  s1_t  s1_q, s1_d, nrm;
  res_t res_q, res_d;
  logic s2_load, s1_adv;

  logic [FP_W-1:0] rnd_z;
  logic rnd_ovf, rnd_unf, rnd_inx;

  fp_round_rne u_rnd (
    .sign   (s1_q.sign),
    .exp    (s1_q.exp),
    .mant   (s1_q.mant),
    .guard  (s1_q.guard),
    .sticky (s1_q.sticky),
    .zero   (s1_q.zero),
    .z      (rnd_z),
    .ovf    (rnd_ovf),
    .unf    (rnd_unf),
    .inx    (rnd_inx)
  );

  always_comb begin
    s2_load = ~o_valid_q | io.iReady;
    s1_adv  = ~s1_valid_q | s2_load;

    nrm.sign = io.iSign;
    nrm.zero = io.iZero;
    if (io.iFrac[47]) begin
      nrm.mant   = io.iFrac[46:24];
      nrm.guard  = io.iFrac[23];
      nrm.sticky = |io.iFrac[22:0];
      nrm.exp    = io.iExp + IEXP_W'(1);
    end else begin
      nrm.mant   = io.iFrac[45:23];
      nrm.guard  = io.iFrac[22];
      nrm.sticky = |io.iFrac[21:0];
      nrm.exp    = io.iExp;
    end

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = io.iValid;
      if (io.iValid) s1_d = nrm;
    end

    o_valid_d = o_valid_q;
    res_d     = res_q;
    if (s2_load) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d.z   = rnd_z;
        res_d.ovf = rnd_ovf;
        res_d.unf = rnd_unf;
        res_d.inx = rnd_inx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      o_valid_q  <= 1'b0;
      res_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      o_valid_q  <= o_valid_d;
      res_q      <= res_d;
    end
  end

  assign io.oReady     = s1_adv;
  assign io.oValid     = o_valid_q;
  assign io.oZ         = res_q.z;
  assign io.oOverflow  = res_q.ovf;
  assign io.oUnderflow = res_q.unf;
  assign io.oInexact   = res_q.inx;
endmodule

// File: tb/tb_fp_mul_round_normalize.sv
// Scoreboard bench for the FP32 normalize/round pipe.
// Directed vectors, random normals, stall and reset.
module tb_fp_mul_round_normalize;
  import fp_mul_round_normalize_pkg::*;

  typedef struct {
    logic [31:0] z;
    logic        o;
    logic        u;
    logic        x;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_asserts = 0;
  int   n_fail = 0;
  exp_t sb[$];

  fp_mul_round_normalize_if io();

  fp_mul_round_normalize dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] ex);
    n_asserts++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, ex);
    end
  endtask

  task automatic check1(string tag,
                        logic obs, logic ex);
    n_asserts++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, ex);
    end
  endtask

  function automatic exp_t mk(logic [31:0] z,
                              logic o, logic u,
                              logic x);
    exp_t r;
    r.z = z; r.o = o; r.u = u; r.x = x;
    return r;
  endfunction

  function automatic exp_t model(logic s,
                                 logic [9:0] e,
                                 logic [47:0] f,
                                 logic zr);
    exp_t r;
    logic [47:0] m;
    logic [23:0] keep, rem;
    logic [24:0] k;
    logic up;
    int ee;
    m  = f;
    ee = int'($signed(e));
    if (m[47]) ee = ee + 1;
    else m = m << 1;
    keep = m[47:24];
    rem  = m[23:0];
    up = (rem > 24'h80_0000) ||
         (rem == 24'h80_0000 && keep[0]);
    k = {1'b0, keep} + 25'(up);
    if (k[24]) begin
      ee = ee + 1;
      k  = k >> 1;
    end
    r = mk({s, 31'h0}, 1'b0, 1'b0, 1'b0);
    if (zr) return r;
    if (ee >= 255) begin
      r = mk({s, 8'hFF, 23'h0}, 1'b1, 1'b0, 1'b1);
    end else if (ee <= 0) begin
      r = mk({s, 31'h0}, 1'b0, 1'b1, 1'b1);
    end else begin
      r.z = {s, ee[7:0], k[22:0]};
      r.x = (rem != 24'h0);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t ex;
    if (!reset && io.oValid && io.iReady) begin
      if (sb.size() == 0) begin
        check1("unexpected_ovalid", io.oValid, 1'b0);
      end else begin
        ex = sb.pop_front();
        check("oZ", io.oZ, ex.z);
        check1("oOverflow", io.oOverflow, ex.o);
        check1("oUnderflow", io.oUnderflow, ex.u);
        check1("oInexact", io.oInexact, ex.x);
      end
    end
  end

  task automatic send(logic s, logic [9:0] e,
                      logic [47:0] f, logic zr,
                      exp_t ex);
    logic acc;
    acc = 1'b0;
    io.iValid = 1'b1;
    io.iSign  = s;
    io.iExp   = e;
    io.iFrac  = f;
    io.iZero  = zr;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge clk);
      if (io.oReady) begin
        sb.push_back(ex);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check1("send_accept", acc, 1'b1);
  endtask

  task automatic sendm(logic s, logic [9:0] e,
                       logic [47:0] f, logic zr);
    send(s, e, f, zr, model(s, e, f, zr));
  endtask

  task automatic idle();
    io.iValid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  logic [31:0] held_z;

  initial begin
    logic [47:0] f;
    logic [9:0]  e;
    io.iValid = 1'b0;
    io.iSign  = 1'b0;
    io.iExp   = '0;
    io.iFrac  = '0;
    io.iZero  = 1'b0;
    io.iReady = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_ovalid", io.oValid, 1'b0);
    check("rst_oz", io.oZ, 32'h0);
    check1("rst_ovf", io.oOverflow, 1'b0);
    check1("rst_unf", io.oUnderflow, 1'b0);
    check1("rst_inx", io.oInexact, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check1("rst_oready", io.oReady, 1'b1);
    @(posedge clk);
    #1;

    send(1'b0, 10'(BIAS), 48'h4000_0000_0000, 1'b0,
         mk(32'h3F80_0000, 1'b0, 1'b0, 1'b0));
    idle();
    @(negedge clk);
    check1("lat_c1", io.oValid, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check1("lat_c2", io.oValid, 1'b1);
    @(posedge clk);
    #1;
    drain();

    send(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0,
         mk(32'h4010_0000, 1'b0, 1'b0, 1'b0));
    send(1'b0, 10'd127, 48'h4000_0040_0000, 1'b0,
         mk(32'h3F80_0000, 1'b0, 1'b0, 1'b1));
    send(1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0,
         mk(32'h3F80_0002, 1'b0, 1'b0, 1'b1));
    send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0,
         mk(32'h4000_0000, 1'b0, 1'b0, 1'b1));
    send(1'b1, 10'd254, 48'h8000_0000_0000, 1'b0,
         mk(32'hFF80_0000, 1'b1, 1'b0, 1'b1));
    send(1'b0, 10'd0, 48'h4000_0000_0000, 1'b0,
         mk(32'h0000_0000, 1'b0, 1'b1, 1'b1));
    send(1'b1, 10'd127, 48'h0, 1'b1,
         mk(32'h8000_0000, 1'b0, 1'b0, 1'b0));
    send(1'b0, 10'd300, 48'h4000_0000_0000, 1'b1,
         mk(32'h0000_0000, 1'b0, 1'b0, 1'b0));
    sendm(1'b0, 10'h3FB, 48'hC000_0000_0000, 1'b0);
    sendm(1'b1, 10'd253, 48'hFFFF_FFFF_FFFF, 1'b0);
    sendm(1'b0, 10'd1, 48'h4000_0000_0001, 1'b0);
    for (int i = 0; i < 24; i++) begin
      f = {$urandom, $urandom};
      if (!f[47]) f[46] = 1'b1;
      e = 10'($urandom_range(1, 253));
      sendm(1'($urandom), e, f, 1'b0);
    end
    idle();
    drain();

    io.iReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          f = {$urandom, $urandom};
          f[47] = 1'b1;
          sendm(1'b0, 10'd100 + 10'(i), f, 1'b0);
        end
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        check1("bp_oready_low", io.oReady, 1'b0);
        check("bp_accepts", sb.size(), 2);
        check1("bp_ovalid", io.oValid, 1'b1);
        held_z = io.oZ;
        repeat (2) begin
          @(negedge clk);
          check("bp_hold_z", io.oZ, held_z);
          check1("bp_hold_rdy", io.oReady, 1'b0);
        end
        @(posedge clk);
        #1;
        io.iReady = 1'b1;
      end
    join
    drain();

    io.iReady = 1'b0;
    sendm(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0);
    sendm(1'b1, 10'd130, 48'h9000_0000_0000, 1'b0);
    idle();
    #2;
    reset = 1'b1;
    #1;
    check1("mid_rst_ovalid", io.oValid, 1'b0);
    check("mid_rst_oz", io.oZ, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    io.iReady = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check1("post_rst_ovalid", io.oValid, 1'b0);
    end
    check1("post_rst_oready", io.oReady, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end
endmodule
